// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, req/valid fetch handshake with
// instruction memory, instruction register and retired-instruction counter.
module fetch_unit #(
    parameter int ADDR_W  = 5,
    parameter int OPC_W   = 4,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               jmp_sel,
    input  logic               stall,
    output logic [OPC_W-1:0]   opcode,
    output logic [ADDR_W-1:0]  operand,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        EXEC  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_STEP = CNT_W'(1);

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic [CNT_W-1:0]   retired_reg, retired_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pc_reg      <= '0;
            ir_reg      <= '0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            retired_reg <= retired_next;
        end
    end

    // IR only loads while a request is outstanding, so stray valids in
    // IDLE/EXEC (e.g. a late response after reset) never disturb it.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        retired_next = retired_reg;
        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (imem_valid) begin
                    ir_next    = imem_data;
                    state_next = EXEC;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_valid) begin
                    ir_next    = imem_data;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_next      = jmp_sel ? ir_reg[ADDR_W-1:0] : pc_reg + PC_STEP;
                    retired_next = retired_reg + CNT_STEP;
                    state_next   = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and qualifier outputs decode straight from the state flops,
    // so imem_req falls the instant rst is asserted.
    assign imem_req    = (state_reg == FETCH) || (state_reg == WAIT);
    assign instr_valid = (state_reg == EXEC);
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign opcode      = ir_reg[INSTR_W-1:ADDR_W];
    assign operand     = ir_reg[ADDR_W-1:0];
    assign retired     = retired_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table of inputs and expected
// outputs, plus hand-written reset-in-WAIT sequence.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       imem_req;
    logic [4:0] imem_addr;
    logic       imem_valid = 1'b0;
    logic [8:0] imem_data = 9'h0;
    logic       jmp_sel = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] opcode;
    logic [4:0] operand;
    logic       instr_valid;
    logic [4:0] pc;
    logic [7:0] retired;

    fetch_unit #(.ADDR_W(5), .OPC_W(4), .INSTR_W(9), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .jmp_sel(jmp_sel), .stall(stall),
        .opcode(opcode), .operand(operand),
        .instr_valid(instr_valid), .pc(pc), .retired(retired)
    );

    always #5 clk = ~clk;

    // One record per clock: inputs applied for that cycle, outputs expected in it.
    typedef struct {
        logic       v;
        logic [8:0] d;
        logic       j;
        logic       s;
        logic       req;
        logic [4:0] addr;
        logic       iv;
        logic [8:0] ir;
        logic [7:0] ret;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    logic [4:0] pc_e;
    logic [7:0] ret_e;
    logic [8:0] ir_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void push(input logic v, input logic [8:0] d, input logic j,
                                 input logic s, input logic req, input logic iv);
        vec_t t;
        t.v = v; t.d = d; t.j = j; t.s = s;
        t.req = req; t.addr = pc_e; t.iv = iv; t.ir = ir_e; t.ret = ret_e;
        vq.push_back(t);
    endfunction

    // One instruction: FETCH, 'waits' WAIT cycles (valid on the last), 'stalls'
    // stalled EXEC cycles, then the committing EXEC. jmp_sel is held high in
    // FETCH/WAIT and imem_valid with junk data in EXEC; both must be ignored.
    function automatic void gen_instr(input logic [8:0] word, input int waits, input logic jmp,
                                      input int stalls, input logic [4:0] next_pc);
        if (waits == 0) begin
            push(1'b1, word, 1'b1, 1'b0, 1'b1, 1'b0);
        end else begin
            push(1'b0, 9'h0, 1'b1, 1'b0, 1'b1, 1'b0);
            for (int w = 1; w <= waits; w++)
                push(w == waits, (w == waits) ? word : 9'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        ir_e = word;
        for (int s = 0; s < stalls; s++)
            push(1'b1, 9'h1FF, s[0], 1'b1, 1'b0, 1'b1);
        push(1'b1, 9'h1FF, jmp, 1'b0, 1'b0, 1'b1);
        pc_e  = next_pc;
        ret_e = ret_e + 8'd1;
    endfunction

    task automatic run_vectors();
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            cyc++;
            check($sformatf("c%0d req", cyc), 32'(imem_req), 32'(vq[i].req));
            check($sformatf("c%0d addr", cyc), 32'(imem_addr), 32'(vq[i].addr));
            check($sformatf("c%0d pc", cyc), 32'(pc), 32'(vq[i].addr));
            check($sformatf("c%0d instr_valid", cyc), 32'(instr_valid), 32'(vq[i].iv));
            check($sformatf("c%0d opcode", cyc), 32'(opcode), 32'(vq[i].ir[8:5]));
            check($sformatf("c%0d operand", cyc), 32'(operand), 32'(vq[i].ir[4:0]));
            check($sformatf("c%0d retired", cyc), 32'(retired), 32'(vq[i].ret));
            imem_valid = vq[i].v;
            imem_data  = vq[i].d;
            jmp_sel    = vq[i].j;
            stall      = vq[i].s;
        end
        vq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req"}, 32'(imem_req), 32'd0);
        check({tag, " addr"}, 32'(imem_addr), 32'd0);
        check({tag, " pc"}, 32'(pc), 32'd0);
        check({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, " opcode"}, 32'(opcode), 32'd0);
        check({tag, " operand"}, 32'(operand), 32'd0);
        check({tag, " retired"}, 32'(retired), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        pc_e = 5'd0; ret_e = 8'd0; ir_e = 9'h0;
        // IDLE: valid and jmp_sel are ignored, IR stays 0
        push(1'b1, 9'h1AB, 1'b1, 1'b0, 1'b0, 1'b0);
        // Zero-wait memory, word[a] = 9'h021 + a, sequential
        for (int a = 0; a < 4; a++)
            gen_instr(9'h021 + 9'(a), 0, 1'b0, 0, 5'(a + 1));
        // Two wait cycles per fetch
        gen_instr(9'h025, 2, 1'b0, 0, 5'd5);
        gen_instr(9'h026, 2, 1'b0, 0, 5'd6);
        // Jump to 3, then jump to 17 from pc=3; back to 3, then no-jump gives 4
        gen_instr({4'h3, 5'd3}, 0, 1'b1, 0, 5'd3);
        gen_instr({4'h5, 5'd17}, 0, 1'b1, 0, 5'd17);
        gen_instr({4'h2, 5'd3}, 0, 1'b1, 0, 5'd3);
        gen_instr({4'h5, 5'd17}, 0, 1'b0, 0, 5'd4);
        // pc=31 sequential wraps to 0
        gen_instr({4'h6, 5'd31}, 0, 1'b1, 0, 5'd31);
        gen_instr({4'h7, 5'd12}, 0, 1'b0, 0, 5'd0);
        // Three stall cycles in EXEC, then commit
        gen_instr({4'h9, 5'd22}, 0, 1'b0, 3, 5'd1);
        // Self-jump re-fetches the same address
        gen_instr({4'h4, 5'd1}, 1, 1'b1, 0, 5'd1);
        run_vectors();

        // Retire up to 255, then wrap to 0 on a jump to 9
        while (ret_e != 8'd255)
            gen_instr({4'hA, 5'd0}, 0, 1'b0, 0, pc_e + 5'd1);
        gen_instr({4'hB, 5'd9}, 0, 1'b1, 0, 5'd9);
        push(1'b0, 9'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        push(1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_vectors();

        // Now in WAIT at pc=9 with the request outstanding; reset asynchronously
        @(posedge clk);
        #1;
        check("wait req", 32'(imem_req), 32'd1);
        check("wait addr", 32'(imem_addr), 32'd9);
        rst = 1'b1;
        #1 check_reset_outputs("async reset");
        imem_valid = 1'b0;
        jmp_sel    = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Late valid while IDLE is ignored; first fetch re-requests address 0
        pc_e = 5'd0; ret_e = 8'd0; ir_e = 9'h0;
        push(1'b1, 9'h1AB, 1'b0, 1'b0, 1'b0, 1'b0);
        gen_instr(9'h0C3, 1, 1'b0, 0, 5'd1);
        push(1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_vectors();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
